ark_stream_master: RTL

- Initiator and reader for the byte-serial AddRoundKey stage of the AES-128 datapath.
- Takes a 128-bit state and 128-bit round key in parallel and streams both, one byte per cycle, MSB byte first, into the stage's column/key inputs.
- Then collects the 16 XORed bytes the stage returns under its output-enable and reassembles them into a 128-bit result with a done pulse.
- Sits between the parallel control logic and the serial round stage.

---
 rtl/ark_stream_master.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ark_stream_master.sv
// ---------------------------------------------------------------------------
// ark_stream_master
//
// Parallel-to-serial initiator and serial-to-parallel reader for the
// byte-serial AddRoundKey stage of an AES-128 datapath.
//
// A 128-bit state and round key are latched on start, streamed one byte per
// cycle (MSB byte first) into the stage, and the 16 XORed bytes the stage
// returns under res_en are reassembled into a 128-bit result with a one-cycle
// done pulse.
//
// Handshake: en_col/en_key are asserted together for exactly NBYTES
// consecutive cycles while a block is sent and are never asserted otherwise;
// res_din is accepted in every cycle where res_en is high while the block is
// waiting for or collecting returned bytes, and is ignored at all other times.
//
// Optional feature (macro ARK_TIMEOUT_EN): a watchdog counts cycles spent
// waiting for or collecting returned bytes. On reaching TIMEOUT_CYC it aborts
// the operation with err=1 and a done pulse, leaving result unchanged. err
// stays high until the next accepted start. Without the macro err is tied 0
// and the block waits indefinitely.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start               begin an operation (sampled in IDLE only)
//   state_in, key_in    128-bit block and round key, byte i = [127-8i -: 8]
//   col_dout, key_dout  byte stream towards the stage
//   en_col, en_key      byte stream valid
//   res_din, res_en     returned byte and its enable
//   result              reassembled 128-bit block, held until next done
//   busy                high from accepted start until done
//   done                one-cycle pulse when result (or err) is valid
//   err                 timeout flag
// ---------------------------------------------------------------------------
module ark_stream_master #(
  parameter int NBYTES      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  output logic [7:0]   col_dout,
  output logic [7:0]   key_dout,
  output logic         en_col,
  output logic         en_key,
  input  logic [7:0]   res_din,
  input  logic         res_en,
  output logic [127:0] result,
  output logic         busy,
  output logic         done,
  output logic         err
);

  // Only the AES-128 geometry is supported.
  if (NBYTES != 16 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("ark_stream_master: NBYTES must be 16 and TIMEOUT_CYC >= 2");
  end

  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_WAIT    = 2'd2,
    S_COLLECT = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] st_sh_q, st_sh_d;    // state shadow, shifted left per sent byte
  logic [127:0] key_sh_q, key_sh_d;  // key shadow, shifted in lockstep
  logic [127:0] buf_q, buf_d;        // collection buffer, bytes shift in at LSB
  logic [127:0] result_q, result_d;
  logic         done_q, done_d;
  logic [127:0] buf_shift;
  logic         accept;

  // The cycle that shows done is still the tail of the finished operation,
  // so a start coinciding with done is not taken.
  assign accept    = (state_q == S_IDLE) && start && !done_q;
  assign buf_shift = {buf_q[119:0], res_din};

`ifdef ARK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    st_sh_d  = st_sh_q;
    key_sh_d = key_sh_q;
    buf_d    = buf_q;
    result_d = result_q;
    done_d   = 1'b0;
`ifdef ARK_TIMEOUT_EN
    err_d    = err_q;
    tmo_d    = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          st_sh_d  = state_in;
          key_sh_d = key_in;
          cnt_d    = 4'd0;
          state_d  = S_SEND;
`ifdef ARK_TIMEOUT_EN
          err_d    = 1'b0;
`endif
        end
      end

      S_SEND: begin
        st_sh_d  = {st_sh_q[119:0], 8'h00};
        key_sh_d = {key_sh_q[119:0], 8'h00};
        if (cnt_q == LAST_IDX) begin
          cnt_d   = 4'd0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_WAIT: begin
        if (res_en) begin
          buf_d   = buf_shift;
          cnt_d   = 4'd1;
          state_d = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (res_en) begin
          buf_d = buf_shift;
          if (cnt_q == LAST_IDX) begin
            result_d = buf_shift;
            done_d   = 1'b1;
            cnt_d    = 4'd0;
            state_d  = S_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef ARK_TIMEOUT_EN
    // Watchdog restarts on the way into WAIT and runs until the block
    // completes. A completion on the expiring cycle wins over the abort.
    if (state_q == S_SEND) begin
      tmo_d = '0;
    end else if (state_q == S_WAIT || state_q == S_COLLECT) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_q == TMO_LAST && state_d != S_IDLE) begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      st_sh_q  <= '0;
      key_sh_q <= '0;
      buf_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      st_sh_q  <= st_sh_d;
      key_sh_q <= key_sh_d;
      buf_q    <= buf_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

`ifdef ARK_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Stream outputs are driven straight from the state register and the top
  // byte of each shadow, so they are glitch-free and zero outside SEND.
  assign en_col   = (state_q == S_SEND);
  assign en_key   = (state_q == S_SEND);
  assign col_dout = en_col ? st_sh_q[127:120] : 8'h00;
  assign key_dout = en_key ? key_sh_q[127:120] : 8'h00;
  assign result   = result_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

endmodule
